// File: rtl/deskew_pkg.sv
// Shared types and sizing helpers for the receive-side deskew controller.
// The skew limit is derived from the tolerated bit skew and the 66-bit block width.
package deskew_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_AM,
        MEASURE,
        CHECK,
        ALIGNED
    } state_e;

    localparam int BLOCK_W      = 66;
    localparam int MAX_BIT_SKEW = 1856;

    function automatic int calc_max_skew(input int bit_skew, input int block_w);
        return (bit_skew - block_w - 1) / block_w;
    endfunction

    localparam int MAX_SKEW_DEFAULT = calc_max_skew(MAX_BIT_SKEW, BLOCK_W);

    function automatic int calc_skew_w(input int max_skew);
        return $clog2(max_skew + 1);
    endfunction

    function automatic int calc_tmr_w(input int am_period, input int max_skew, input int lat);
        return $clog2(am_period + max_skew + lat + 1);
    endfunction

endpackage

// File: rtl/deskew_ctrl_lane_rx.sv
// Per-lane marker arrival stamp: records the arrival count of the first marker
// and flags a second marker seen before the lane set has been fully stamped.
module deskew_ctrl_lane_rx
    import deskew_pkg::*;
#(
    parameter int SKEW_W = calc_skew_w(MAX_SKEW_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              am_i,
    input  logic [SKEW_W-1:0] cnt_i,
    output logic [SKEW_W-1:0] stamp_nxt_o,
    output logic              stamped_nxt_o,
    output logic              double_am_o
);

    logic [SKEW_W-1:0] stamp_q, stamp_d;
    logic              stamped_q, stamped_d;

    always_comb begin
        stamp_d   = stamp_q;
        stamped_d = stamped_q;
        if (clr_i) begin
            stamp_d   = '0;
            stamped_d = 1'b0;
        end else if (en_i && am_i && !stamped_q) begin
            stamp_d   = cnt_i;
            stamped_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stamp_q   <= '0;
            stamped_q <= 1'b0;
        end else begin
            stamp_q   <= stamp_d;
            stamped_q <= stamped_d;
        end
    end

    assign stamp_nxt_o   = stamp_d;
    assign stamped_nxt_o = stamped_d;
    assign double_am_o   = en_i && am_i && stamped_q;

endmodule

// File: rtl/deskew_ctrl_rx.sv
// Receive alignment controller: measures per-lane marker skew, programs the
// deskew buffer delays, confirms alignment and owns align_status.
module deskew_ctrl_rx
    import deskew_pkg::*;
#(
    parameter int LANE_N           = 4,
    parameter int MAX_SKEW_BLOCK_N = MAX_SKEW_DEFAULT,
    parameter int AM_PERIOD        = 16384,
    parameter int DESKEW_LAT       = 1,
    localparam int SKEW_W          = calc_skew_w(MAX_SKEW_BLOCK_N)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_i,
    input  logic [LANE_N-1:0]        am_lite_lock_v_i,
    input  logic [LANE_N-1:0]        am_lite_lock_lost_v_i,
    input  logic [LANE_N-1:0]        am_lite_v_i,
    input  logic [LANE_N-1:0]        deskew_am_v_i,
    output logic [LANE_N*SKEW_W-1:0] delay_o,
    output logic                     deskew_rst_o,
    output logic                     align_status_o,
    output logic                     skew_err_o
);

    // cnt must be able to hold MAX+1 so the overrun is detectable
    localparam int CNT_W = $clog2(MAX_SKEW_BLOCK_N + 2);
    localparam int TMR_W = calc_tmr_w(AM_PERIOD, MAX_SKEW_BLOCK_N, DESKEW_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_SKEW_BLOCK_N);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(AM_PERIOD + MAX_SKEW_BLOCK_N + DESKEW_LAT);

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [TMR_W-1:0]               tmr_q, tmr_d;
    logic [LANE_N-1:0][SKEW_W-1:0]  delay_q, delay_d;
    logic                           deskew_rst_q, deskew_rst_d;
    logic                           align_q, align_d;
    logic                           err_q, err_d;

    logic [LANE_N-1:0][SKEW_W-1:0]  stamp_nxt;
    logic [LANE_N-1:0]              stamped_nxt;
    logic [LANE_N-1:0]              double_am;
    logic [SKEW_W-1:0]              stamp_max;
    logic                           abort;
    logic                           overrun;
    logic                           lane_en;
    logic                           lane_clr;

    assign abort = (state_q != IDLE) &&
                   ((|am_lite_lock_lost_v_i) || !(&am_lite_lock_v_i));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE || abort) begin
            cnt_d = '0;
        end else if (valid_i && state_q == WAIT_AM) begin
            cnt_d = '0;
        end else if (valid_i && state_q == MEASURE) begin
            cnt_d = cnt_q + 1'b1;
        end
        overrun  = (state_q == MEASURE) && (cnt_d > CNT_MAX);
        lane_en  = valid_i && !abort && !overrun &&
                   (state_q == WAIT_AM || state_q == MEASURE);
        lane_clr = (state_q == IDLE);
    end

    for (genvar i = 0; i < LANE_N; i++) begin : g_lane
        deskew_ctrl_lane_rx #(.SKEW_W(SKEW_W)) u_lane (
            .clk          (clk),
            .reset        (reset),
            .clr_i        (lane_clr),
            .en_i         (lane_en),
            .am_i         (am_lite_v_i[i]),
            .cnt_i        (SKEW_W'(cnt_d)),
            .stamp_nxt_o  (stamp_nxt[i]),
            .stamped_nxt_o(stamped_nxt[i]),
            .double_am_o  (double_am[i])
        );
    end

    always_comb begin
        stamp_max = '0;
        for (int i = 0; i < LANE_N; i++) begin
            if (stamp_nxt[i] > stamp_max) stamp_max = stamp_nxt[i];
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        delay_d = delay_q;
        err_d   = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else if (valid_i) begin
            case (state_q)
                IDLE: begin
                    if (&am_lite_lock_v_i) state_d = WAIT_AM;
                end
                // zero skew stamps every lane in WAIT_AM and goes straight to CHECK
                WAIT_AM, MEASURE: begin
                    if ((|double_am) || overrun) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (&stamped_nxt) begin
                        state_d = CHECK;
                        for (int i = 0; i < LANE_N; i++) begin
                            delay_d[i] = stamp_max - stamp_nxt[i];
                        end
                    end else if (|stamped_nxt) begin
                        state_d = MEASURE;
                    end
                end
                CHECK: begin
                    tmr_d = tmr_q + 1'b1;
                    if (|deskew_am_v_i) begin
                        if (&deskew_am_v_i) begin
                            state_d = ALIGNED;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (tmr_d == TMR_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                ALIGNED: begin
                    if ((|deskew_am_v_i) && !(&deskew_am_v_i)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (state_d != CHECK) tmr_d = '0;
        if (state_d == IDLE) delay_d = '0;
        deskew_rst_d = (state_d == IDLE);
        align_d      = (state_d == ALIGNED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tmr_q        <= '0;
            delay_q      <= '0;
            deskew_rst_q <= 1'b1;
            align_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmr_q        <= tmr_d;
            delay_q      <= delay_d;
            deskew_rst_q <= deskew_rst_d;
            align_q      <= align_d;
            err_q        <= err_d;
        end
    end

    assign delay_o        = delay_q;
    assign deskew_rst_o   = deskew_rst_q;
    assign align_status_o = align_q;
    assign skew_err_o     = err_q;

endmodule

// File: tb/tb_deskew_ctrl_rx.sv
// Scoreboard bench for deskew_ctrl_rx: stimulus pushes expected error/align/drop
// events computed from marker offsets; a monitor pops them as the DUT reports.
module tb_deskew_ctrl_rx;

    localparam int LANE_N    = 4;
    localparam int MAX_SKEW  = 27;
    localparam int AM_PERIOD = 32;
    localparam int DLAT      = 1;
    localparam int SKEW_W    = $clog2(MAX_SKEW + 1);
    localparam int LIMIT     = AM_PERIOD + MAX_SKEW + DLAT;
    localparam int EV_ERR    = 0;
    localparam int EV_ALIGN  = 1;
    localparam int EV_DROP   = 2;

    typedef logic [LANE_N*SKEW_W-1:0] dly_t;
    typedef struct {
        int   kind;
        int   cyc;
        dly_t dly;
    } ev_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid;
    logic [LANE_N-1:0] lock, lost, am, dam;
    dly_t              delay_o;
    logic              deskew_rst_o, align_status_o, skew_err_o;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_pass = 0;
    ev_t exp_q[$];

    deskew_ctrl_rx #(
        .LANE_N(LANE_N), .MAX_SKEW_BLOCK_N(MAX_SKEW), .AM_PERIOD(AM_PERIOD), .DESKEW_LAT(DLAT)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .valid_i              (valid),
        .am_lite_lock_v_i     (lock),
        .am_lite_lock_lost_v_i(lost),
        .am_lite_v_i          (am),
        .deskew_am_v_i        (dam),
        .delay_o              (delay_o),
        .deskew_rst_o         (deskew_rst_o),
        .align_status_o       (align_status_o),
        .skew_err_o           (skew_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    endfunction

    function automatic void push(input int kind, input int c, input dly_t d);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.dly  = d;
        exp_q.push_back(e);
    endfunction

    function automatic void observe(input int kind);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: kind %0d at cycle %0d with nothing expected", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.cyc == cyc) n_pass++;
            else $display("FAIL event: got kind %0d cycle %0d expected kind %0d cycle %0d",
                          kind, cyc, e.kind, e.cyc);
            if (kind == EV_ALIGN) check("align_delay", 64'(delay_o), 64'(e.dly));
        end
        if (kind == EV_ALIGN) begin
            check("align_rst", 64'(deskew_rst_o), 64'd0);
        end else begin
            check("idle_rst", 64'(deskew_rst_o), 64'd1);
            check("idle_delay", 64'(delay_o), 64'd0);
        end
    endfunction

    // monitor
    initial begin
        logic prev_align;
        prev_align = 1'b0;
        forever begin
            @(negedge clk);
            if (skew_err_o === 1'b1) observe(EV_ERR);
            if (align_status_o === 1'b1 && !prev_align) observe(EV_ALIGN);
            if (align_status_o === 1'b0 && prev_align) observe(EV_DROP);
            prev_align = (align_status_o === 1'b1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic relock();
        valid = 1'b1; lock = '1; lost = '0; am = '0; dam = '0;
        step();
        step();
    endtask

    // off[i] < 0 means lane i never marks; abort_at >= 0 drops lane 1's lock at that step
    task automatic do_measure(input int off[LANE_N], input int gap_at, input int gap_len,
                              input int abort_at, output bit ok, output dly_t dly);
        int  mx, last;
        bit  miss, aborted;
        mx = 0; miss = 1'b0;
        for (int i = 0; i < LANE_N; i++) begin
            if (off[i] < 0) miss = 1'b1;
            else if (off[i] > mx) mx = off[i];
        end
        ok   = !miss && mx <= MAX_SKEW;
        last = ok ? mx : MAX_SKEW + 1;
        aborted = abort_at >= 0 && abort_at <= last;
        if (aborted) last = abort_at;
        dly = '0;
        for (int i = 0; i < LANE_N; i++)
            if (ok) dly[i*SKEW_W +: SKEW_W] = SKEW_W'(mx - off[i]);
        for (int t = 0; t <= last; t++) begin
            if (t == gap_at) begin
                repeat (gap_len) begin
                    valid = 1'b0; am = LANE_N'($urandom);
                    step();
                end
            end
            valid = 1'b1;
            for (int i = 0; i < LANE_N; i++) am[i] = (off[i] == t);
            if (aborted && t == last) lost = 4'b0010;
            if (!aborted && !ok && t == last) push(EV_ERR, cyc + 1, '0);
            step();
        end
        am = '0; lost = '0;
        if (aborted) begin
            ok = 1'b0;
            check("abort_rst", 64'(deskew_rst_o), 64'd1);
            check("abort_delay", 64'(delay_o), 64'd0);
        end else if (ok) begin
            check("measure_delay", 64'(delay_o), 64'(dly));
            check("measure_rst", 64'(deskew_rst_o), 64'd0);
            check("measure_align", 64'(align_status_o), 64'd0);
        end
    endtask

    // mode 0: aligned marker, 1: partial marker pat, 2: no marker until timer expiry
    task automatic do_check(input int mode, input int wait_n, input logic [LANE_N-1:0] pat,
                            input dly_t dly);
        valid = 1'b1; am = '0; dam = '0;
        if (mode == 2) begin
            for (int j = 1; j <= LIMIT; j++) begin
                if (j == LIMIT) push(EV_ERR, cyc + 1, '0);
                step();
            end
        end else begin
            repeat (wait_n) step();
            dam = (mode == 0) ? '1 : pat;
            push(mode == 0 ? EV_ALIGN : EV_ERR, cyc + 1, dly);
            step();
            dam = '0;
        end
    endtask

    // mode 0: partial marker, 1: lock-lost pulse on lane, 2: lock drop on lane
    task automatic do_aligned(input int mode, input int n_ok, input int lane);
        repeat (n_ok) begin
            valid = ($urandom_range(0, 3) != 0);
            dam = valid ? ($urandom_range(0, 1) ? '1 : '0) : LANE_N'($urandom);
            step();
        end
        valid = 1'b1; dam = '0;
        case (mode)
            0: begin
                dam = LANE_N'($urandom_range(1, (1 << LANE_N) - 2));
                push(EV_ERR, cyc + 1, '0);
            end
            1: lost[lane] = 1'b1;
            default: lock[lane] = 1'b0;
        endcase
        push(EV_DROP, cyc + 1, '0);
        step();
        dam = '0; lost = '0;
    endtask

    initial begin
        int   offs[LANE_N];
        bit   ok;
        dly_t dly;
        reset = 1'b1; valid = 1'b0; lock = '0; lost = '0; am = '0; dam = '0;
        repeat (3) step();
        check("rst_delay", 64'(delay_o), 64'd0);
        check("rst_deskew_rst", 64'(deskew_rst_o), 64'd1);
        check("rst_align", 64'(align_status_o), 64'd0);
        check("rst_err", 64'(skew_err_o), 64'd0);
        reset = 1'b0;

        // skews {0,2,1,4}, align, then lock lost on lane 2
        relock(); offs = '{0, 2, 1, 4};
        do_measure(offs, -1, 0, -1, ok, dly);
        do_check(0, 5, '0, dly);
        do_aligned(1, 3, 2);
        // relock with skews {3,0,0,1}, exit on a partial marker
        relock(); offs = '{3, 0, 0, 1};
        do_measure(offs, -1, 0, -1, ok, dly);
        do_check(0, 10, '0, dly);
        do_aligned(0, 4, 0);
        // lane 3 never marks
        relock(); offs = '{0, 0, 0, -1};
        do_measure(offs, -1, 0, -1, ok, dly);
        // partial check marker, then check timer expiry
        relock(); offs = '{1, 0, 2, 0};
        do_measure(offs, -1, 0, -1, ok, dly);
        do_check(1, 3, 4'b1011, dly);
        relock(); offs = '{0, 5, 0, 2};
        do_measure(offs, -1, 0, -1, ok, dly);
        do_check(2, 0, '0, dly);
        // valid gap mid-measure
        relock(); offs = '{0, 1, 2, 3};
        do_measure(offs, 2, 5, -1, ok, dly);
        do_check(0, 0, '0, dly);
        do_aligned(2, 2, 3);
        // reset mid-measure
        relock();
        am = 4'b0001; step();
        am = 4'b0010; step();
        am = '0; reset = 1'b1; step();
        check("midrst_delay", 64'(delay_o), 64'd0);
        check("midrst_deskew_rst", 64'(deskew_rst_o), 64'd1);
        check("midrst_align", 64'(align_status_o), 64'd0);
        check("midrst_err", 64'(skew_err_o), 64'd0);
        reset = 1'b0;
        // lock lost together with the last marker
        relock(); offs = '{0, 2, 1, 4};
        do_measure(offs, -1, 0, 4, ok, dly);
        // zero skew, check marker on the final timer cycle
        relock(); offs = '{0, 0, 0, 0};
        do_measure(offs, -1, 0, -1, ok, dly);
        do_check(0, LIMIT - 1, '0, dly);
        do_aligned(1, 2, 0);
        // largest tolerated skew, then one beyond
        relock(); offs = '{0, 27, 5, 9};
        do_measure(offs, -1, 0, -1, ok, dly);
        do_check(0, 2, '0, dly);
        do_aligned(0, 1, 0);
        relock(); offs = '{0, 28, 3, 3};
        do_measure(offs, -1, 0, -1, ok, dly);

        for (int s = 0; s < 15; s++) begin
            int k, md;
            relock();
            for (int i = 0; i < LANE_N; i++) offs[i] = $urandom_range(0, 30);
            k = $urandom_range(0, LANE_N - 1);
            offs[k] = 0;
            if ($urandom_range(0, 7) == 0) offs[(k + 1) % LANE_N] = -1;
            do_measure(offs, $urandom_range(0, 6), $urandom_range(0, 3), -1, ok, dly);
            if (ok) begin
                md = $urandom_range(0, 3);
                if (md == 3) begin
                    do_check(2, 0, '0, dly);
                end else if (md == 2) begin
                    do_check(1, $urandom_range(0, LIMIT - 1),
                             LANE_N'($urandom_range(1, (1 << LANE_N) - 2)), dly);
                end else begin
                    do_check(0, $urandom_range(0, LIMIT - 1), '0, dly);
                    do_aligned($urandom_range(0, 2), $urandom_range(0, 6),
                               $urandom_range(0, LANE_N - 1));
                end
            end
        end

        relock();
        repeat (4) step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/deskew_ctrl_rx.md
Name: deskew_ctrl_rx

Overview:
Receive-side alignment controller for the multi-lane PCS deskew datapath. It watches per-lane alignment-marker lock and marker-arrival strobes from the am_lite lock blocks and measures each lane's arrival skew. It programs the per-lane delay selects of the deskew buffer, then confirms alignment on the next marker period. It owns align_status and its loss/recovery sequencing.

Parameters:
LANE_N, 4, number of PCS lanes.
MAX_SKEW_BLOCK_N, 27, largest tolerated inter-lane skew in blocks ((1856-66-1)/66).
AM_PERIOD, 16384, valid blocks between markers on one lane; the bench overrides it to 32.
DESKEW_LAT, 1, deskew buffer latency from delay_o update to aligned output.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
valid_i  in  1  block strobe; all counters advance only when high
am_lite_lock_v_i  in  LANE_N  per-lane marker lock held
am_lite_lock_lost_v_i  in  LANE_N  per-lane lock-lost pulse
am_lite_v_i  in  LANE_N  per-lane marker seen this block (pre-deskew)
deskew_am_v_i  in  LANE_N  marker flags at the deskew buffer output
delay_o  out  LANE_N*SKEW_W  per-lane delay select, in blocks; lane i at bits [i*SKEW_W +: SKEW_W]
deskew_rst_o  out  1  clears deskew buffer contents
align_status_o  out  1  all lanes aligned
skew_err_o  out  1  one-cycle pulse: skew exceeded or check failed

Behaviour:
- Reset values: state IDLE, delay_o=0, deskew_rst_o=1, align_status_o=0, skew_err_o=0, all counters and arrival stamps 0.
- Global abort, evaluated in every state except IDLE: any am_lite_lock_lost_v_i bit high, or any am_lite_lock_v_i bit low, sends the FSM to IDLE next cycle. In that cycle align_status_o=0, delay_o=0 and deskew_rst_o=1. Abort takes priority over every simultaneous event.
- IDLE: deskew_rst_o=1. Move to WAIT_AM when am_lite_lock_v_i is all ones.
- WAIT_AM: deskew_rst_o=0.
  - On the first valid cycle with any am_lite_v_i bit set, go to MEASURE.
  - That cycle is arrival 0 for every set lane; arrival counter cnt=0.
- MEASURE, per valid cycle:
  - cnt increments.
  - Each lane whose am_lite_v_i is set and not yet stamped records stamp=cnt.
  - A second marker on an already-stamped lane raises skew_err_o and returns to IDLE.
  - If cnt reaches MAX_SKEW_BLOCK_N+1 before all lanes are stamped, raise skew_err_o and return to IDLE.
  - When the last lane is stamped (at most cnt=MAX_SKEW_BLOCK_N), the next cycle sets delay_o[i]=stamp_max-stamp[i] and enters CHECK.
  - Width rule: SKEW_W=$clog2(MAX_SKEW_BLOCK_N+1). The subtraction is unsigned and never negative.
- CHECK:
  - A timer counts valid cycles up to AM_PERIOD+MAX_SKEW_BLOCK_N+DESKEW_LAT.
  - First nonzero deskew_am_v_i equal to all ones: go to ALIGNED and set align_status_o=1 on the next cycle.
  - First nonzero deskew_am_v_i that is partial: skew_err_o, go to IDLE.
  - Timer expiry with no marker: skew_err_o, go to IDLE.
- ALIGNED:
  - align_status_o=1; delay_o held.
  - deskew_am_v_i all ones is accepted.
  - Partial deskew_am_v_i: skew_err_o, go to IDLE; align_status_o drops the following cycle.
- Zero skew (all markers in one cycle): MEASURE is skipped; all delays are 0 and CHECK is entered the next cycle.
- valid_i low: FSM and counters freeze; abort conditions still apply.
- deskew_rst_o is high for exactly the cycles in IDLE.

Decomposition:
- Shared package deskew_pkg holds:
  - state enum {IDLE, WAIT_AM, MEASURE, CHECK, ALIGNED};
  - SKEW_W and the check-timer width function;
  - the MAX_SKEW_BLOCK_N derivation from bit skew and block width.
- One sub-module, deskew_ctrl_lane_rx, instantiated LANE_N times. Per lane it holds the stamp register, stamped flag and duplicate-marker detect, and outputs the stamp plus a double_am error.
- The top contains the FSM, cnt, check timer, max reduction and subtraction.

Test Plan:
1. Lock all 4 lanes; markers at offsets {0,2,1,4}; then aligned markers one period later -> delay_o={4,2,3,0}, align_status_o=1 one cycle after the check marker, skew_err_o never pulses.
2. Lane 3 locked but never marks; lanes 0-2 mark at 0 -> skew_err_o pulses once at cnt=28, then IDLE with deskew_rst_o=1 and delay_o=0.
3. While ALIGNED, am_lite_lock_lost_v_i=4'b0100 for one cycle -> align_status_o=0 next cycle, deskew_rst_o=1; relock plus skews {3,0,0,1} -> delay_o={0,3,3,2}, ALIGNED.
4. In CHECK, deskew_am_v_i=4'b1011 -> skew_err_o pulse, IDLE; with AM_PERIOD=32, no check marker for 32+27+1 valid cycles -> skew_err_o pulse at expiry.
5. valid_i low for 5 cycles mid-MEASURE, skews {0,1,2,3} -> stamps unaffected, delay_o={3,2,1,0}; in a separate run, reset pulsed mid-MEASURE -> all outputs at reset values next cycle.
6. Lock lost on lane 1 in the same cycle the last marker arrives in MEASURE -> IDLE, no delay_o update, no skew_err_o.
